// File: rtl/coin_pkg.sv
// Shared definitions for the coin front end of the vending machine.
// Provides the coin codes, their credit values, the collector state encoding
// and the credit ceiling.
package coin_pkg;

    // Coin codes as presented on coin_type.
    localparam logic [2:0] COIN_1  = 3'b000;
    localparam logic [2:0] COIN_2  = 3'b001;
    localparam logic [2:0] COIN_5  = 3'b010;
    localparam logic [2:0] COIN_10 = 3'b011;
    localparam logic [2:0] COIN_20 = 3'b100;
    localparam logic [2:0] COIN_50 = 3'b101;

    // Credit value of each coin.
    localparam logic [6:0] VALUE_1  = 7'd1;
    localparam logic [6:0] VALUE_2  = 7'd2;
    localparam logic [6:0] VALUE_5  = 7'd5;
    localparam logic [6:0] VALUE_10 = 7'd10;
    localparam logic [6:0] VALUE_20 = 7'd20;
    localparam logic [6:0] VALUE_50 = 7'd50;

    // Largest credit the 7-bit register can hold.
    localparam int unsigned MAX_CREDIT = 127;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCollect = 2'b01,
        StLocked  = 2'b10,
        StRefund  = 2'b11
    } coin_state_e;

endpackage

// File: rtl/coin_decode.sv
// Combinational coin decoder.
// Ports:
//   coin_type_i - 3-bit coin code
//   value_o     - credit value of the coin (0 for invalid codes)
//   valid_o     - high when the code names a real coin
module coin_decode
    import coin_pkg::*;
(
    input  logic [2:0] coin_type_i,
    output logic [6:0] value_o,
    output logic       valid_o
);

    always_comb begin
        value_o = 7'd0;
        valid_o = 1'b1;
        unique case (coin_type_i)
            COIN_1:  value_o = VALUE_1;
            COIN_2:  value_o = VALUE_2;
            COIN_5:  value_o = VALUE_5;
            COIN_10: value_o = VALUE_10;
            COIN_20: value_o = VALUE_20;
            COIN_50: value_o = VALUE_50;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/coin_collector.sv
// Coin collector: validates coins, accumulates the running credit, freezes it
// while a purchase is in progress and refunds an abandoned session.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   coin_valid_i/type_i   - coin strobe and code
//   lock_i                - level, freezes credit for a transaction
//   clear_i               - pulse, zeroes the credit
//   total_coin_value_o    - registered credit
//   coin_accept_o/reject_o- one-cycle result pulse for each coin
//   session_active_o      - high in COLLECT and LOCKED
//   timeout_refund_o      - one-cycle refund pulse
//   refund_value_o        - credit being refunded, 0 otherwise
module coin_collector
    import coin_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       coin_valid_i,
    input  logic [2:0] coin_type_i,
    input  logic       lock_i,
    input  logic       clear_i,
    output logic [6:0] total_coin_value_o,
    output logic       coin_accept_o,
    output logic       coin_reject_o,
    output logic       session_active_o,
    output logic       timeout_refund_o,
    output logic [6:0] refund_value_o
);

    localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MaxSum  = 8'(MAX_CREDIT);

    coin_state_e     state_q, state_d;
    logic [6:0]      credit_q, credit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept_q, accept_d;
    logic            reject_q, reject_d;

    logic [6:0] coin_value;
    logic       coin_ok;
    logic [7:0] sum;
    logic       coin_add;

    coin_decode u_decode (
        .coin_type_i (coin_type_i),
        .value_o     (coin_value),
        .valid_o     (coin_ok)
    );

    // 8-bit sum so an overflowing coin is caught rather than wrapped.
    assign sum      = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_add = coin_valid_i && !lock_i && !clear_i && coin_ok && (sum <= MaxSum) &&
                      ((state_q == StIdle) || (state_q == StCollect));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            credit_q <= 7'd0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
        end
    end

    // Priority: clear > lock > coin > timeout.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = '0;
        accept_d = coin_valid_i && coin_add;
        reject_d = coin_valid_i && !coin_add;
        unique case (state_q)
            StIdle: begin
                if (lock_i) begin
                    state_d = StLocked;
                end else if (coin_add) begin
                    state_d  = StCollect;
                    credit_d = sum[6:0];
                end
            end
            StCollect: begin
                if (clear_i) begin
                    state_d  = StIdle;
                    credit_d = 7'd0;
                end else if (lock_i) begin
                    state_d = StLocked;
                end else if (coin_add) begin
                    credit_d = sum[6:0];
                end else if (cnt_q == CntLast) begin
                    state_d = StRefund;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLocked: begin
                if (clear_i) begin
                    state_d  = StIdle;
                    credit_d = 7'd0;
                end
            end
            StRefund: begin
                state_d  = StIdle;
                credit_d = 7'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        total_coin_value_o = credit_q;
        coin_accept_o      = accept_q;
        coin_reject_o      = reject_q;
        session_active_o   = (state_q == StCollect) || (state_q == StLocked);
        timeout_refund_o   = (state_q == StRefund);
        refund_value_o     = (state_q == StRefund) ? credit_q : 7'd0;
    end

endmodule

// File: tb/tb_coin_collector.sv
module tb_coin_collector;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [2:0] coin_type = 3'b000;
    logic       lock = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] total;
    logic       acc;
    logic       rej;
    logic       sess;
    logic       refund;
    logic [6:0] rval;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    coin_collector #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .coin_valid_i       (coin_valid),
        .coin_type_i        (coin_type),
        .lock_i             (lock),
        .clear_i            (clear),
        .total_coin_value_o (total),
        .coin_accept_o      (acc),
        .coin_reject_o      (rej),
        .session_active_o   (sess),
        .timeout_refund_o   (refund),
        .refund_value_o     (rval)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: session phase (0 idle, 1 collecting, 2 locked, 3 refunding),
    // credit in plain integers, and how long the session has gone without a coin.
    int vals[8] = '{1, 2, 5, 10, 20, 50, -1, -1};
    int m_phase = 0;
    int m_credit = 0;
    int m_quiet = 0;
    int e_total = 0, e_acc = 0, e_rej = 0, e_sess = 0, e_ref = 0, e_rv = 0;

    always @(posedge clk) begin : model
        int v;
        bit ok;
        int np, nc, nq;
        v  = vals[coin_type];
        np = m_phase;
        nc = m_credit;
        nq = 0;
        ok = 1'b0;
        if (rst) begin
            np = 0;
            nc = 0;
            e_acc <= 0;
            e_rej <= 0;
        end else begin
            ok = coin_valid && (m_phase <= 1) && !lock && !clear && (v >= 0) &&
                 (m_credit + v <= 127);
            e_acc <= (coin_valid && ok) ? 1 : 0;
            e_rej <= (coin_valid && !ok) ? 1 : 0;
            if (m_phase == 3) begin
                np = 0;
                nc = 0;
            end else if (clear && m_phase != 0) begin
                np = 0;
                nc = 0;
            end else if (lock) begin
                np = 2;
            end else if (ok) begin
                np = 1;
                nc = m_credit + v;
            end else if (m_phase == 1) begin
                // Session abandoned once T quiet edges have passed since the last coin.
                if (m_quiet + 1 >= T) np = 3;
                else nq = m_quiet + 1;
            end
        end
        m_phase  <= np;
        m_credit <= nc;
        m_quiet  <= nq;
        e_total  <= nc;
        e_sess   <= (np == 1 || np == 2) ? 1 : 0;
        e_ref    <= (np == 3) ? 1 : 0;
        e_rv     <= (np == 3) ? nc : 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_total", int'(total), e_total);
            check("model_accept", int'(acc), e_acc);
            check("model_reject", int'(rej), e_rej);
            check("model_session", int'(sess), e_sess);
            check("model_refund", int'(refund), e_ref);
            check("model_refund_value", int'(rval), e_rv);
        end
    end

    // Drive one cycle of inputs; returns just after the sampling edge.
    task automatic cyc(input bit r, input bit v, input bit [2:0] t, input bit l, input bit c);
        @(negedge clk);
        rst        = r;
        coin_valid = v;
        coin_type  = t;
        lock       = l;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'b000, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_total", int'(total), 0);
        check("reset_session", int'(sess), 0);
        check("reset_refund", int'(refund), 0);
        check("reset_accept", int'(acc), 0);

        // Coins 10, 20, 50.
        cyc(0, 1, 3'b011, 0, 0);
        check("c10_accept", int'(acc), 1);
        check("c10_total", int'(total), 10);
        cyc(0, 1, 3'b100, 0, 0);
        check("c20_total", int'(total), 30);
        cyc(0, 1, 3'b101, 0, 0);
        check("c50_total", int'(total), 80);
        cyc(0, 0, 3'b000, 1, 0);
        cyc(0, 0, 3'b000, 1, 0);
        check("lock_hold", int'(total), 80);
        check("lock_session", int'(sess), 1);
        cyc(0, 0, 3'b000, 1, 1);
        check("clear_total", int'(total), 0);
        check("clear_session", int'(sess), 0);

        // Overflow and invalid code.
        cyc(0, 1, 3'b101, 0, 0);
        cyc(0, 1, 3'b100, 0, 0);
        cyc(0, 1, 3'b011, 0, 0);
        cyc(0, 1, 3'b101, 0, 0);
        check("ovf_reject", int'(rej), 1);
        check("ovf_accept", int'(acc), 0);
        check("ovf_total", int'(total), 80);
        cyc(0, 1, 3'b100, 0, 0);
        check("c20b_total", int'(total), 100);
        cyc(0, 1, 3'b110, 0, 0);
        check("bad_reject", int'(rej), 1);
        check("bad_total", int'(total), 100);
        cyc(0, 0, 3'b000, 0, 1);
        check("clear2_total", int'(total), 0);

        // Lock and coin together.
        cyc(0, 1, 3'b010, 1, 0);
        check("lockcoin_reject", int'(rej), 1);
        check("lockcoin_session", int'(sess), 1);
        cyc(0, 1, 3'b000, 1, 0);
        check("locked_reject", int'(rej), 1);
        check("locked_total", int'(total), 0);
        cyc(0, 0, 3'b000, 0, 1);
        check("clear3_session", int'(sess), 0);

        // Timeout refund.
        cyc(0, 1, 3'b100, 0, 0);
        idle(T - 1);
        check("pre_timeout", int'(refund), 0);
        idle(1);
        check("timeout_pulse", int'(refund), 1);
        check("timeout_value", int'(rval), 20);
        idle(1);
        check("post_refund_total", int'(total), 0);
        check("post_refund_session", int'(sess), 0);
        check("post_refund_pulse", int'(refund), 0);

        // Coin in the timeout cycle.
        cyc(0, 1, 3'b100, 0, 0);
        idle(T - 1);
        cyc(0, 1, 3'b000, 0, 0);
        check("late_coin_accept", int'(acc), 1);
        check("late_coin_no_refund", int'(refund), 0);
        check("late_coin_total", int'(total), 21);
        idle(T - 1);
        check("restart_no_refund", int'(refund), 0);
        idle(1);
        check("restart_refund", int'(refund), 1);
        check("restart_value", int'(rval), 21);
        idle(1);

        // Clear and lock together with credit 55.
        cyc(0, 1, 3'b101, 0, 0);
        cyc(0, 1, 3'b010, 0, 0);
        check("c55_total", int'(total), 55);
        cyc(0, 0, 3'b000, 1, 1);
        check("clrlock_total", int'(total), 0);
        check("clrlock_session", int'(sess), 0);
        idle(1);
        check("clrlock_idle", int'(sess), 0);

        // Reset while locked with a coin in flight.
        cyc(0, 1, 3'b101, 0, 0);
        cyc(0, 1, 3'b100, 0, 0);
        cyc(0, 0, 3'b000, 1, 0);
        check("c70_locked", int'(total), 70);
        cyc(1, 1, 3'b000, 0, 0);
        check("rst_total", int'(total), 0);
        check("rst_accept", int'(acc), 0);
        check("rst_reject", int'(rej), 0);
        check("rst_session", int'(sess), 0);
        check("rst_refund", int'(refund), 0);
        cyc(0, 1, 3'b000, 0, 0);
        check("after_rst_accept", int'(acc), 1);
        check("after_rst_total", int'(total), 1);
        idle(3);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
